// File: rtl/input_conditioner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// input_conditioner
// Debounces buttons and turns coin presses into frame-aligned, queued pulses.
// Revision: 1.0
// ============================================================================
module input_conditioner #(
   parameter int NBTN        = 8,
   parameter int DB_W        = 16,
   parameter int DB_CYCLES   = 40000,
   parameter int COIN_FRAMES = 3,
   parameter int GAP_FRAMES  = 3,
   parameter int QDEPTH      = 3
) (
   input  logic            clk_sys,
   input  logic            reset_n,
   input  logic [NBTN-1:0] btn_in,
   input  logic            coin_in,
   input  logic            vs,
   output logic [NBTN-1:0] btn_out,
   output logic            coin_out,
   output logic [1:0]      coin_pending,
   output logic            coin_drop
);

   localparam int              c_NCH       = NBTN + 1;
   localparam logic [DB_W-1:0] c_DB_MAX    = DB_W'(DB_CYCLES - 1);
   localparam logic [3:0]      c_COIN_LAST = 4'(COIN_FRAMES - 1);
   localparam logic [3:0]      c_GAP_LAST  = 4'(GAP_FRAMES - 1);
   localparam logic [1:0]      c_QFULL     = 2'(QDEPTH);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_PULSE = 2'd1;
   localparam logic [1:0] c_ST_GAP   = 2'd2;

   logic [c_NCH-1:0] r_sync1;
   logic [c_NCH-1:0] r_sync2;
   logic [c_NCH-1:0] w_db;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= {coin_in, btn_in};
         r_sync2 <= r_sync1;
      end
   end

   // Coin is debounced as the extra channel at index NBTN.
   for (genvar g = 0; g < c_NCH; g++) begin : g_db
      logic [DB_W-1:0] r_cnt;
      logic            r_out;

      always_ff @(posedge clk_sys or negedge reset_n) begin
         if (!reset_n) begin
            r_cnt <= '0;
            r_out <= 1'b0;
         end else if (r_sync2[g] != r_out) begin
            if (r_cnt == c_DB_MAX) begin
               r_out <= r_sync2[g];
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end

      assign w_db[g] = r_out;
   end

   logic       r_coin_d;
   logic       r_vs_d;
   logic [1:0] r_state;
   logic [3:0] r_fcnt;
   logic [1:0] r_pending;
   logic       r_coin_out;
   logic       r_drop;

   logic w_coin_rise;
   logic w_vs_rise;
   logic w_deq;

   assign w_coin_rise = w_db[NBTN] & ~r_coin_d;
   assign w_vs_rise   = vs & ~r_vs_d;
   assign w_deq       = (r_state == c_ST_IDLE) && (r_pending != 2'd0) && w_vs_rise;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_coin_d  <= 1'b0;
         r_vs_d    <= 1'b0;
         r_pending <= 2'd0;
         r_drop    <= 1'b0;
      end else begin
         r_coin_d <= w_db[NBTN];
         r_vs_d   <= vs;
         r_drop   <= 1'b0;
         // A dequeue and an enqueue on the same edge cancel, even when full.
         if (w_coin_rise && !w_deq) begin
            if (r_pending == c_QFULL) begin
               r_drop <= 1'b1;
            end else begin
               r_pending <= r_pending + 2'd1;
            end
         end else if (!w_coin_rise && w_deq) begin
            r_pending <= r_pending - 2'd1;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= c_ST_IDLE;
         r_fcnt     <= 4'd0;
         r_coin_out <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_deq) begin
                  r_state    <= c_ST_PULSE;
                  r_coin_out <= 1'b1;
                  r_fcnt     <= 4'd0;
               end
            end
            c_ST_PULSE: begin
               if (w_vs_rise) begin
                  if (r_fcnt == c_COIN_LAST) begin
                     r_state    <= c_ST_GAP;
                     r_coin_out <= 1'b0;
                     r_fcnt     <= 4'd0;
                  end else begin
                     r_fcnt <= r_fcnt + 4'd1;
                  end
               end
            end
            c_ST_GAP: begin
               if (w_vs_rise) begin
                  if (r_fcnt == c_GAP_LAST) begin
                     r_state <= c_ST_IDLE;
                     r_fcnt  <= 4'd0;
                  end else begin
                     r_fcnt <= r_fcnt + 4'd1;
                  end
               end
            end
            default: begin
               r_state    <= c_ST_IDLE;
               r_fcnt     <= 4'd0;
               r_coin_out <= 1'b0;
            end
         endcase
      end
   end

   assign btn_out      = w_db[NBTN-1:0];
   assign coin_out     = r_coin_out;
   assign coin_pending = r_pending;
   assign coin_drop    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_input_conditioner
// Directed self-checking bench for input_conditioner (DB_CYCLES=4).
// Revision: 1.0
// ============================================================================
module tb_input_conditioner;

   localparam int NBTN      = 8;
   localparam int DB_CYCLES = 4;
   localparam int VS_PERIOD = 100;

   logic            clk_sys = 1'b0;
   logic            reset_n = 1'b0;
   logic [NBTN-1:0] btn_in  = '0;
   logic            coin_in = 1'b0;
   logic            vs      = 1'b0;
   logic [NBTN-1:0] btn_out;
   logic            coin_out;
   logic [1:0]      coin_pending;
   logic            coin_drop;

   int errors = 0;
   int checks = 0;
   int vphase = VS_PERIOD - 1;
   bit vs_run = 1'b0;

   input_conditioner #(
      .NBTN        (NBTN),
      .DB_W        (16),
      .DB_CYCLES   (DB_CYCLES),
      .COIN_FRAMES (3),
      .GAP_FRAMES  (3),
      .QDEPTH      (3)
   ) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .btn_in       (btn_in),
      .coin_in      (coin_in),
      .vs           (vs),
      .btn_out      (btn_out),
      .coin_out     (coin_out),
      .coin_pending (coin_pending),
      .coin_drop    (coin_drop)
   );

   always #5 clk_sys = ~clk_sys;

   // One clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk_sys);
      #1;
      if (vs_run) begin
         vphase = (vphase + 1) % VS_PERIOD;
         vs = (vphase < 4);
      end
   endtask

   task automatic wait_phase(input int p);
      while (vphase != p) tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      btn_in  = 8'hFF;
      coin_in = 1'b0;
      repeat (5) tick();
      checks++; if (btn_out !== 8'h00) begin errors++; $display("FAIL reset_btn_out got=%h exp=00", btn_out); end
      checks++; if (coin_out !== 1'b0) begin errors++; $display("FAIL reset_coin_out got=%b exp=0", coin_out); end
      checks++; if (coin_pending !== 2'd0) begin errors++; $display("FAIL reset_pending got=%0d exp=0", coin_pending); end
      checks++; if (coin_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", coin_drop); end
      btn_in  = 8'h00;
      reset_n = 1'b1;
      repeat (10) tick();
      checks++; if (btn_out !== 8'h00) begin errors++; $display("FAIL post_reset_btn got=%h exp=00", btn_out); end
   endtask

   task automatic test_debounce();
      int n;
      n = 0;
      btn_in[0] = 1'b1;
      while (btn_out[0] !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++; if (n != 6) begin errors++; $display("FAIL debounce_latency got=%0d exp=6", n); end
   endtask

   task automatic test_glitch();
      logic [3:0] pat;
      int early;
      int n;
      pat   = 4'b0111;
      early = 0;
      for (int i = 0; i < 4; i++) begin
         btn_in[1] = pat[i];
         tick();
         if (btn_out[1] !== 1'b0) early++;
      end
      btn_in[1] = 1'b1;
      n = 0;
      while (btn_out[1] !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++; if (early != 0) begin errors++; $display("FAIL glitch_early got=%0d exp=0", early); end
      checks++; if (n != 6) begin errors++; $display("FAIL glitch_latency got=%0d exp=6", n); end
   endtask

   task automatic test_single_coin();
      int n;
      int w;
      vs_run = 1'b1;
      wait_phase(10);
      coin_in = 1'b1; repeat (8) tick();
      coin_in = 1'b0; repeat (8) tick();
      checks++; if (coin_pending !== 2'd1) begin errors++; $display("FAIL single_pending got=%0d exp=1", coin_pending); end
      checks++; if (coin_out !== 1'b0) begin errors++; $display("FAIL single_midframe got=%b exp=0", coin_out); end
      n = 0;
      while (coin_out !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++; if (coin_out !== 1'b1) begin errors++; $display("FAIL single_start got=%b exp=1", coin_out); end
      checks++; if (vphase != 1) begin errors++; $display("FAIL single_align got=%0d exp=1", vphase); end
      checks++; if (coin_pending !== 2'd0) begin errors++; $display("FAIL single_dequeue got=%0d exp=0", coin_pending); end
      w = 0;
      while (coin_out === 1'b1 && w < 400) begin
         tick();
         w++;
      end
      checks++; if (w != 300) begin errors++; $display("FAIL single_width got=%0d exp=300", w); end
      repeat (450) tick();
   endtask

   task automatic test_burst();
      int drops;
      int pulses;
      int bad_w;
      int min_gap;
      int hi_t;
      int lo_t;
      logic prev;
      drops = 0;
      wait_phase(5);
      for (int k = 0; k < 5; k++) begin
         coin_in = 1'b1;
         repeat (7) begin tick(); if (coin_drop === 1'b1) drops++; end
         coin_in = 1'b0;
         repeat (7) begin tick(); if (coin_drop === 1'b1) drops++; end
      end
      checks++; if (coin_pending !== 2'd3) begin errors++; $display("FAIL burst_saturate got=%0d exp=3", coin_pending); end
      checks++; if (drops != 2) begin errors++; $display("FAIL burst_drops got=%0d exp=2", drops); end
      checks++; if (coin_out !== 1'b0) begin errors++; $display("FAIL burst_midframe got=%b exp=0", coin_out); end
      pulses  = 0;
      bad_w   = 0;
      min_gap = 99999;
      hi_t    = 0;
      lo_t    = -1;
      prev    = coin_out;
      for (int t = 0; t < 2300; t++) begin
         tick();
         if (coin_out === 1'b1 && prev === 1'b0) begin
            pulses++;
            if (lo_t >= 0 && (t - lo_t) < min_gap) min_gap = t - lo_t;
            hi_t = t;
         end
         if (coin_out === 1'b0 && prev === 1'b1) begin
            if ((t - hi_t) != 300) bad_w++;
            lo_t = t;
         end
         prev = coin_out;
      end
      checks++; if (pulses != 3) begin errors++; $display("FAIL burst_pulses got=%0d exp=3", pulses); end
      checks++; if (bad_w != 0) begin errors++; $display("FAIL burst_width got=%0d bad exp=0", bad_w); end
      checks++; if (min_gap < 300) begin errors++; $display("FAIL burst_gap got=%0d exp>=300", min_gap); end
      checks++; if (coin_pending !== 2'd0) begin errors++; $display("FAIL burst_drain got=%0d exp=0", coin_pending); end
   endtask

   task automatic test_simultaneous();
      wait_phase(10);
      coin_in = 1'b1; repeat (8) tick();
      coin_in = 1'b0; repeat (8) tick();
      checks++; if (coin_pending !== 2'd1) begin errors++; $display("FAIL simul_setup got=%0d exp=1", coin_pending); end
      wait_phase(94);
      coin_in = 1'b1;
      repeat (6) tick();
      checks++; if (coin_out !== 1'b0) begin errors++; $display("FAIL simul_early got=%b exp=0", coin_out); end
      tick();
      checks++; if (coin_out !== 1'b1) begin errors++; $display("FAIL simul_coin_out got=%b exp=1", coin_out); end
      checks++; if (coin_pending !== 2'd1) begin errors++; $display("FAIL simul_pending got=%0d exp=1", coin_pending); end
      checks++; if (coin_drop !== 1'b0) begin errors++; $display("FAIL simul_drop got=%b exp=0", coin_drop); end
      coin_in = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_reset_mid_pulse();
      int highs;
      int n;
      coin_in = 1'b1; repeat (8) tick();
      coin_in = 1'b0; repeat (8) tick();
      checks++; if (coin_out !== 1'b1) begin errors++; $display("FAIL mid_pre_out got=%b exp=1", coin_out); end
      checks++; if (coin_pending !== 2'd2) begin errors++; $display("FAIL mid_pre_pending got=%0d exp=2", coin_pending); end
      #3 reset_n = 1'b0;
      #1;
      checks++; if (coin_out !== 1'b0) begin errors++; $display("FAIL mid_async_out got=%b exp=0", coin_out); end
      checks++; if (coin_pending !== 2'd0) begin errors++; $display("FAIL mid_async_pending got=%0d exp=0", coin_pending); end
      repeat (3) tick();
      reset_n = 1'b1;
      highs = 0;
      repeat (800) begin tick(); if (coin_out !== 1'b0) highs++; end
      checks++; if (highs != 0) begin errors++; $display("FAIL mid_no_pulse got=%0d exp=0", highs); end
      checks++; if (coin_pending !== 2'd0) begin errors++; $display("FAIL mid_queue_lost got=%0d exp=0", coin_pending); end
      coin_in = 1'b1; repeat (8) tick();
      coin_in = 1'b0;
      n = 0;
      while (coin_out !== 1'b1 && n < 250) begin
         tick();
         n++;
      end
      checks++; if (coin_out !== 1'b1) begin errors++; $display("FAIL mid_new_coin got=%b exp=1", coin_out); end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_glitch();
      test_single_coin();
      test_burst();
      test_simultaneous();
      test_reset_mid_pulse();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
